// File: rtl/shift_left_unit.sv
// Sequential shift-left engine: loads a word, shifts it left one bit per clock, serialises MSBs.
// Define SHIFT_LEFT_ROTATE_EN to refill the LSB with the outgoing MSB (rotate-left).
module shift_left_unit #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [N-1:0]  data_i,
  input  logic [AW-1:0] amt_i,
  output logic          ready_o,
  output logic          busy_o,
  output logic [N-1:0]  data_o,
  output logic          sdo_o,
  output logic          sdo_valid_o,
  output logic          carry_o,
  output logic          done_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        r_state, w_state_d;
  logic [N-1:0]  r_shift, w_shift_d;
  logic [AW-1:0] r_cnt, w_cnt_d;
  logic          r_carry, w_carry_d;
  logic          w_fill;

`ifdef SHIFT_LEFT_ROTATE_EN
  assign w_fill = r_shift[N-1];
`else
  assign w_fill = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_cnt_d   = r_cnt;
    w_carry_d = r_carry;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_shift_d = data_i;
          w_cnt_d   = amt_i;
          w_carry_d = 1'b0;
          w_state_d = (amt_i != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        w_shift_d = {r_shift[N-2:0], w_fill};
        w_carry_d = r_carry | r_shift[N-1];
        w_cnt_d   = r_cnt - AW'(1);
        if (r_cnt == AW'(1)) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_cnt   <= w_cnt_d;
      r_carry <= w_carry_d;
    end
  end

  // Every output is a decode of registered state only.
  assign ready_o     = (r_state == StIdle);
  assign busy_o      = (r_state == StShift);
  assign sdo_valid_o = (r_state == StShift);
  assign done_o      = (r_state == StDone);
  assign data_o      = r_shift;
  assign sdo_o       = r_shift[N-1];
  assign carry_o     = r_carry;

endmodule

// File: doc/shift_left_unit.md
# shift_left_unit

Sequential logical shift-left engine. It accepts an N-bit word and a shift amount through a start/ready handshake, then shifts the word left one position per clock. Each bit leaving the MSB is presented on a serial output, and a one-cycle completion pulse marks the end of the operation. It is the left-direction companion of the team's right-shift register, used in the same datapath for multi-cycle scaling and serialisation.

## Interface
- N, 8, data width (≥2)
- AW, 3, width of shift amount; amounts 0..2^AW-1
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request; accepted only when ready_o=1
- data_i  in  N  operand, sampled at accept edge
- amt_i  in  AW  shift count, sampled at accept edge
- ready_o  out  1  high in IDLE only
- busy_o  out  1  high in SHIFT only
- data_o  out  N  working/result register
- sdo_o  out  1  bit leaving MSB at the next edge (shift_reg[N-1])
- sdo_valid_o  out  1  qualifies sdo_o; equals busy_o
- carry_o  out  1  sticky OR of all bits shifted out of the MSB
- done_o  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state: IDLE.
- IDLE: ready_o=1. On start_i=1, at the edge:
  - load shift_reg←data_i, cnt←amt_i, carry←0
  - go to SHIFT if amt_i≠0, else go to DONE
- SHIFT: each edge:
  - shift_reg←{shift_reg[N-2:0],fill}, with fill=0 (logical)
  - carry←carry|shift_reg[N-1]
  - cnt←cnt−1
  - go to DONE on the edge where cnt==1
- DONE: done_o=1 for exactly one cycle, then IDLE. data_o holds the result until the next accept.
- start_i outside IDLE is ignored and not queued. Operand/amount changes after accept have no effect.
- Width rules: amounts ≥N produce data_o=0. carry_o then equals the OR of the whole original operand. cnt is AW bits wide with no wrap.
- Reset, including mid-operation: immediately forces IDLE, data_o=0, carry_o=0, done_o=0, busy_o=0, sdo_valid_o=0, ready_o=1. The operation in flight is discarded.
- Reset values: ready_o=1; every other output is 0.

## Timing
- Accept edge is E0.
- Shift edges are E1..E_amt. sdo_o/sdo_valid_o are valid in the cycle before each shift edge.
- done_o is high in the single cycle after edge E_amt. For amt=0, that is the cycle after E0.
- ready_o rises after E_amt+1. Throughput is one operation per amt+2 cycles.
- All outputs are decoded from registers; there is no combinational path from inputs to outputs.

## Configuration
- SHIFT_LEFT_ROTATE_EN
  - Defined: fill=shift_reg[N-1], giving rotate-left. data_o after N shifts equals the operand. carry_o still accumulates the bits passing through the MSB.
  - Undefined: fill=0, giving logical shift.
- All FSM, handshake and timing behaviour is identical in both builds.

## Test plan
All cases use N=8, AW=3.
- Reset: assert rst_i between edges → outputs update without waiting for a clock: data_o=0x00, ready_o=1, done_o=0, carry_o=0, busy_o=0.
- data_i=0x96, amt_i=3 → sdo_o sequence 1,0,0 with sdo_valid_o high for 3 cycles. data_o=0xB0, carry_o=1, done_o high in the cycle after E3. With SHIFT_LEFT_ROTATE_EN: data_o=0xB4.
- data_i=0x5A, amt_i=0 → sdo_valid_o never high, done_o in the cycle after E0, data_o=0x5A, carry_o=0, ready_o back after E1.
- data_i=0x01, amt_i=7 → data_o=0x80, carry_o=0. data_i=0xFF, amt_i=7 → data_o=0x80, carry_o=1 (rotate build: 0xFF, carry_o=1).
- start_i held high continuously with new data_i each cycle → only IDLE-cycle requests are accepted. Back-to-back operations are spaced amt+2 cycles; data_i changes during SHIFT/DONE do not alter the result.
- rst_i pulsed at E2 of an amt_i=5 operation → immediate IDLE, data_o=0, no done_o pulse. A following request with data_i=0x03, amt_i=1 completes normally with data_o=0x06.
